// File: rtl/cr_cp0_int_seq.sv
`default_nettype none
// ============================================================================
// Module   : cr_cp0_int_seq
// Purpose  : CLIC interrupt-take sequencer. Arbitrates a pending CLIC request
//            against the current level, enable, debug and exception state.
//            Handshakes with the pipeline (ack) before emitting a one-cycle
//            take strobe. For hardware-vectored interrupts it then drives the
//            vector-table fetch request until done/fail.
// Ports    : forever_cpuclk/cpurst_b  - clock, async active-low reset
//            clic_cpu_int_*           - pending CLIC request (vld,id,il,hv)
//            cp0_iu_il/mie_for_int    - current mil and global enable
//            iu_yy_xx_dbgon/iu_cp0_expt_vld - debug mode / exception blockers
//            iu_intseq_ack            - pipeline drained, ok to take
//            vec_intseq_done/fail     - vector fetch completion
//            iui_oreg_inst_mret/status_oreg_intr - CLIC exit generation
//            intseq_iu_req, iu_cp0_int_vld, iu_yy_xx_int_id/il/hv,
//            intseq_vec_req, intseq_vec_err, cpu_clic_int_exit, intseq_busy
// Config   : INT_SEQ_VEC_TIMEOUT_EN - adds an 8-bit VEC watchdog that
//            forces an error exit after 255 counts without done/fail.
// Revision : 1.0 - initial release
// ============================================================================
module cr_cp0_int_seq (
   input  logic       forever_cpuclk,
   input  logic       cpurst_b,
   input  logic       clic_cpu_int_vld,
   input  logic [9:0] clic_cpu_int_id,
   input  logic [7:0] clic_cpu_int_il,
   input  logic       clic_cpu_int_hv,
   input  logic [7:0] cp0_iu_il,
   input  logic       cp0_iu_mie_for_int,
   input  logic       iu_yy_xx_dbgon,
   input  logic       iu_cp0_expt_vld,
   input  logic       iu_intseq_ack,
   input  logic       vec_intseq_done,
   input  logic       vec_intseq_fail,
   input  logic       iui_oreg_inst_mret,
   input  logic       status_oreg_intr,
   output logic       intseq_iu_req,
   output logic       iu_cp0_int_vld,
   output logic [9:0] iu_yy_xx_int_id,
   output logic [7:0] iu_yy_xx_int_il,
   output logic       iu_yy_xx_int_hv,
   output logic       intseq_vec_req,
   output logic       intseq_vec_err,
   output logic       cpu_clic_int_exit,
   output logic       intseq_busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] TAKE = 2'd2;
   localparam logic [1:0] VEC  = 2'd3;

   logic [1:0] state_q,   state_d;
   logic [9:0] hold_id_q, hold_id_d;
   logic [7:0] hold_il_q, hold_il_d;
   logic       hold_hv_q, hold_hv_d;
   logic [9:0] last_id_q;
   logic [7:0] last_il_q;
   logic       last_hv_q;
   logic       vec_err_q, vec_err_d;
   logic       elig;

   // Blocking exception also appears in elig, so an exception coinciding
   // with ack automatically wins and drops the sequencer back to IDLE.
   assign elig = clic_cpu_int_vld && (clic_cpu_int_il > cp0_iu_il) &&
                 cp0_iu_mie_for_int && !iu_yy_xx_dbgon && !iu_cp0_expt_vld;

`ifdef INT_SEQ_VEC_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
`endif

   always_comb begin
      state_d   = state_q;
      hold_id_d = hold_id_q;
      hold_il_d = hold_il_q;
      hold_hv_d = hold_hv_q;
      vec_err_d = 1'b0;
`ifdef INT_SEQ_VEC_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (elig) begin
               state_d   = REQ;
               hold_id_d = clic_cpu_int_id;
               hold_il_d = clic_cpu_int_il;
               hold_hv_d = clic_cpu_int_hv;
            end
         end
         REQ: begin
            // Reload while eligible so a higher-level request preempts.
            if (elig) begin
               hold_id_d = clic_cpu_int_id;
               hold_il_d = clic_cpu_int_il;
               hold_hv_d = clic_cpu_int_hv;
               if (iu_intseq_ack) begin
                  state_d = TAKE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         TAKE: begin
            state_d = hold_hv_q ? VEC : IDLE;
`ifdef INT_SEQ_VEC_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
         end
         VEC: begin
            // Debug mode deliberately does not abort an in-flight fetch.
            if (vec_intseq_done || vec_intseq_fail) begin
               state_d   = IDLE;
               vec_err_d = vec_intseq_fail;
`ifdef INT_SEQ_VEC_TIMEOUT_EN
            end else if (cnt_q == 8'hFF) begin
               state_d   = IDLE;
               vec_err_d = 1'b1;
            end else begin
               cnt_d     = cnt_q + 8'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q   <= IDLE;
         hold_id_q <= 10'd0;
         hold_il_q <= 8'd0;
         hold_hv_q <= 1'b0;
         last_id_q <= 10'd0;
         last_il_q <= 8'd0;
         last_hv_q <= 1'b0;
         vec_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_id_q <= hold_id_d;
         hold_il_q <= hold_il_d;
         hold_hv_q <= hold_hv_d;
         vec_err_q <= vec_err_d;
         // Remember what was actually taken so the outputs stay stable
         // while the holding registers track new pending requests.
         if (state_q == TAKE) begin
            last_id_q <= hold_id_q;
            last_il_q <= hold_il_q;
            last_hv_q <= hold_hv_q;
         end
      end
   end

`ifdef INT_SEQ_VEC_TIMEOUT_EN
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign intseq_iu_req     = (state_q == REQ);
   assign iu_cp0_int_vld    = (state_q == TAKE);
   assign intseq_vec_req    = (state_q == VEC);
   assign intseq_busy       = (state_q != IDLE);
   // Registered so the error pulse lands in the cycle after VEC exits and
   // is cleared immediately by reset.
   assign intseq_vec_err    = vec_err_q;
   assign cpu_clic_int_exit = iui_oreg_inst_mret && status_oreg_intr;
   assign iu_yy_xx_int_id   = (state_q == TAKE) ? hold_id_q : last_id_q;
   assign iu_yy_xx_int_il   = (state_q == TAKE) ? hold_il_q : last_il_q;
   assign iu_yy_xx_int_hv   = (state_q == TAKE) ? hold_hv_q : last_hv_q;

endmodule
`default_nettype wire
